// File: rtl/systolic_pkg.sv
// Shared types, default sizes and the accumulate helper for the systolic tile.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FLUSH,
        DRAIN
    } state_t;

    localparam int DEF_D_W     = 8;
    localparam int DEF_D_W_ACC = 32;
    localparam int DEF_N1      = 8;
    localparam int DEF_N2      = 4;
    localparam int DEF_K_W     = 16;

    // Signed add of two sign-extended w-bit values (w <= 62).
    // sat=0: the caller keeps the low w bits, so the sum wraps.
    // sat=1: the sum clamps to the signed w-bit range.
    function automatic logic signed [63:0] sat_add(
        input logic signed [63:0] x,
        input logic signed [63:0] y,
        input int                 w,
        input logic               sat
    );
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = x + y;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (sat && (s > hi)) return hi;
        if (sat && (s < lo)) return lo;
        return s;
    endfunction

endpackage

// File: rtl/pe_os.sv
// Output-stationary processing element: operands pass east/south, the
// accumulator stays put while loading and shifts east while draining.
module pe_os
    import systolic_pkg::*;
#(
    parameter int D_W      = DEF_D_W,
    parameter int D_W_ACC  = DEF_D_W_ACC,
    parameter int SATURATE = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               advance,
    input  logic               shift_en,
    input  logic [D_W-1:0]     in_a,
    input  logic [D_W-1:0]     in_b,
    input  logic [D_W_ACC-1:0] acc_in,
    output logic [D_W-1:0]     out_a,
    output logic [D_W-1:0]     out_b,
    output logic [D_W_ACC-1:0] acc
);

    logic signed [2*D_W-1:0]   prod;
    logic signed [D_W_ACC-1:0] prod_ext;
    logic        [D_W_ACC-1:0] acc_sum;

    assign prod     = $signed(in_a) * $signed(in_b);
    assign prod_ext = D_W_ACC'(prod);
    assign acc_sum  = D_W_ACC'(sat_add(64'($signed(acc)), 64'(prod_ext),
                                       D_W_ACC, SATURATE != 0));

    // Operand pipeline registers and the accumulator.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every PE
        // samples its neighbours' pre-edge values, whatever the block order.
        if (rst) begin
            out_a <= '0;
            out_b <= '0;
            acc   <= '0;
        end else if (clear) begin
            out_a <= '0;
            out_b <= '0;
            acc   <= '0;
        end else if (shift_en) begin
            acc <= acc_in;
        end else if (advance) begin
            out_a <= in_a;
            out_b <= in_b;
            acc   <= acc_sum;
        end
    end

endmodule

// File: rtl/systolic_os_tile.sv
// Output-stationary N1xN2 matrix-multiply tile with input skew lines,
// tile-control FSM and a ready/valid column drain port.
module systolic_os_tile
    import systolic_pkg::*;
#(
    parameter int D_W      = DEF_D_W,
    parameter int D_W_ACC  = DEF_D_W_ACC,
    parameter int N1       = DEF_N1,
    parameter int N2       = DEF_N2,
    parameter int K_W      = DEF_K_W,
    parameter int SATURATE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [K_W-1:0]        k_len,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N1*D_W-1:0]     A,
    input  logic [N2*D_W-1:0]     B,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N1*D_W_ACC-1:0] out_data,
    output logic                  out_last,
    output logic                  busy
);

    localparam int FC_W = $clog2(N1 + N2);
    localparam int DC_W = $clog2(N2 + 1);

    state_t          state, state_nxt;
    logic [K_W-1:0]  k_reg, beat_cnt;
    logic [FC_W-1:0] flush_cnt;
    logic [DC_W-1:0] drain_cnt;
    logic            accept, advance, clear, shift_en;

    logic [D_W-1:0]     a_w   [N1][N2+1];
    logic [D_W-1:0]     b_w   [N1+1][N2];
    logic [D_W_ACC-1:0] acc_w [N1][N2+1];

    assign accept   = in_valid & in_ready;
    assign advance  = accept | (state == FLUSH);
    assign clear    = (state == IDLE) & start;
    assign shift_en = out_valid & out_ready;
    assign busy     = (state != IDLE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = (k_len == '0) ? FLUSH : LOAD;
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && (beat_cnt == k_reg - K_W'(1))) state_nxt = FLUSH;
            end
            FLUSH: begin
                if (flush_cnt == FC_W'(N1 + N2 - 2)) state_nxt = DRAIN;
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_last  = (drain_cnt == DC_W'(N2 - 1));
                if (out_ready && out_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Tile depth latch plus beat, flush and drain counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_reg     <= '0;
            beat_cnt  <= '0;
            flush_cnt <= '0;
            drain_cnt <= '0;
        end else if (clear) begin
            k_reg     <= k_len;
            beat_cnt  <= '0;
            flush_cnt <= '0;
            drain_cnt <= '0;
        end else begin
            if (accept)           beat_cnt  <= beat_cnt + K_W'(1);
            if (state == FLUSH)   flush_cnt <= flush_cnt + FC_W'(1);
            if (shift_en)         drain_cnt <= drain_cnt + DC_W'(1);
        end
    end

    // A skew: row lane i reaches column 0 after i advance steps.
    for (genvar i = 0; i < N1; i++) begin : g_a_skew
        logic [D_W-1:0] a_src;
        assign a_src = accept ? A[i*D_W +: D_W] : '0;
        if (i == 0) begin : g_direct
            assign a_w[i][0] = a_src;
        end else begin : g_delay
            logic [D_W-1:0] sr [i];
            // Shift the lane by one stage per advance step.
            always_ff @(posedge clk or posedge rst) begin
                // NOTE: the skew stages are reset and cleared like any other
                // state so a fresh tile never sees operands left from the last.
                if (rst || clear) begin
                    for (int s = 0; s < i; s++) sr[s] <= '0;
                end else if (advance) begin
                    sr[0] <= a_src;
                    for (int s = 1; s < i; s++) sr[s] <= sr[s-1];
                end
            end
            assign a_w[i][0] = sr[i-1];
        end
    end

    // B skew: column lane j reaches row 0 after j advance steps.
    for (genvar j = 0; j < N2; j++) begin : g_b_skew
        logic [D_W-1:0] b_src;
        assign b_src = accept ? B[j*D_W +: D_W] : '0;
        if (j == 0) begin : g_direct
            assign b_w[0][j] = b_src;
        end else begin : g_delay
            logic [D_W-1:0] sr [j];
            // Shift the lane by one stage per advance step.
            always_ff @(posedge clk or posedge rst) begin
                if (rst || clear) begin
                    for (int s = 0; s < j; s++) sr[s] <= '0;
                end else if (advance) begin
                    sr[0] <= b_src;
                    for (int s = 1; s < j; s++) sr[s] <= sr[s-1];
                end
            end
            assign b_w[0][j] = sr[j-1];
        end
    end

    // PE grid; the west edge feeds zeros into the drain shift.
    for (genvar i = 0; i < N1; i++) begin : g_row
        assign acc_w[i][0] = '0;
        assign out_data[i*D_W_ACC +: D_W_ACC] = out_valid ? acc_w[i][N2] : '0;
        for (genvar j = 0; j < N2; j++) begin : g_col
            pe_os #(
                .D_W      (D_W),
                .D_W_ACC  (D_W_ACC),
                .SATURATE (SATURATE)
            ) u_pe (
                .clk      (clk),
                .rst      (rst),
                .clear    (clear),
                .advance  (advance),
                .shift_en (shift_en),
                .in_a     (a_w[i][j]),
                .in_b     (b_w[i][j]),
                .acc_in   (acc_w[i][j]),
                .out_a    (a_w[i][j+1]),
                .out_b    (b_w[i+1][j]),
                .acc      (acc_w[i][j+1])
            );
        end
    end

endmodule

// File: tb/tb_systolic_os_tile.sv
// Directed bench for systolic_os_tile: a default 8x4 tile plus two 2x2
// tiles with 16-bit accumulators (wrapping and saturating) sharing stimulus.
module tb_systolic_os_tile;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Default-size tile.
    logic         m_start = 0, m_in_valid = 0, m_out_ready = 0;
    logic [15:0]  m_k = '0;
    logic [63:0]  m_A = '0;
    logic [31:0]  m_B = '0;
    logic         m_in_ready, m_out_valid, m_out_last, m_busy;
    logic [255:0] m_out_data;

    // Small 2x2 tiles, shared inputs.
    logic         s_start = 0, s_in_valid = 0, s_out_ready = 0;
    logic [15:0]  s_k = '0;
    logic [15:0]  s_A = '0;
    logic [15:0]  s_B = '0;
    logic         w_in_ready, w_out_valid, w_out_last, w_busy;
    logic [31:0]  w_out_data;
    logic         c_in_ready, c_out_valid, c_out_last, c_busy;
    logic [31:0]  c_out_data;

    int vectors = 0;
    int miscompares = 0;

    systolic_os_tile u_main (
        .clk(clk), .rst(rst), .start(m_start), .k_len(m_k),
        .in_valid(m_in_valid), .in_ready(m_in_ready), .A(m_A), .B(m_B),
        .out_valid(m_out_valid), .out_ready(m_out_ready), .out_data(m_out_data),
        .out_last(m_out_last), .busy(m_busy)
    );

    systolic_os_tile #(.N1(2), .N2(2), .D_W_ACC(16), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .start(s_start), .k_len(s_k),
        .in_valid(s_in_valid), .in_ready(w_in_ready), .A(s_A), .B(s_B),
        .out_valid(w_out_valid), .out_ready(s_out_ready), .out_data(w_out_data),
        .out_last(w_out_last), .busy(w_busy)
    );

    systolic_os_tile #(.N1(2), .N2(2), .D_W_ACC(16), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .start(s_start), .k_len(s_k),
        .in_valid(s_in_valid), .in_ready(c_in_ready), .A(s_A), .B(s_B),
        .out_valid(c_out_valid), .out_ready(s_out_ready), .out_data(c_out_data),
        .out_last(c_out_last), .busy(c_busy)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_m_valid(input string tag, output int n);
        n = 0;
        while (!m_out_valid && n < 64) begin
            tick();
            n++;
        end
        check(tag, m_out_valid, 1'b1);
    endtask

    task automatic wait_s_valid(input string tag);
        int n = 0;
        while (!w_out_valid && n < 64) begin
            tick();
            n++;
        end
        check(tag, w_out_valid, 1'b1);
    endtask

    // Eight 32-bit lanes, lane i = m0 + step*i.
    function automatic logic [255:0] lanes(input int m0, input int step);
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = 32'(m0 + step * i);
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int col;

        // Reset state, observed while rst is still held.
        #3;
        check("rst in_ready",  m_in_ready, 1'b0);
        check("rst out_valid", m_out_valid, 1'b0);
        check("rst out_last",  m_out_last, 1'b0);
        check("rst busy",      m_busy, 1'b0);
        check("rst out_data",  m_out_data, '0);
        check("rst small busy", {w_busy, c_busy}, 2'b00);
        @(negedge clk);
        rst = 1'b0;

        // 1: 2x2, K=1, A=[3,-2], B=[4,5].
        s_out_ready = 1'b1;
        s_k = 16'd1;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        check("t1 in_ready", w_in_ready, 1'b1);
        s_in_valid = 1'b1;
        s_A = {-8'sd2, 8'sd3};
        s_B = {8'sd5, 8'sd4};
        tick();
        s_in_valid = 1'b0;
        s_A = '0;
        s_B = '0;
        wait_s_valid("t1 valid");
        check("t1 beat0 data", w_out_data, {-16'sd10, 16'sd15});
        check("t1 beat0 sat data", c_out_data, {-16'sd10, 16'sd15});
        check("t1 beat0 last", w_out_last, 1'b0);
        tick();
        check("t1 beat1 data", w_out_data, {-16'sd8, 16'sd12});
        check("t1 beat1 last", w_out_last, 1'b1);
        tick();
        check("t1 idle after", {w_busy, w_out_valid}, 2'b00);

        // 2: default size, K=3, all ones, latency from start.
        m_out_ready = 1'b1;
        m_A = {8{8'sd1}};
        m_B = {4{8'sd1}};
        m_in_valid = 1'b1;
        m_k = 16'd3;
        m_start = 1'b1;
        tick();
        m_start = 1'b0;
        check("t2 in_ready", m_in_ready, 1'b1);
        wait_m_valid("t2 valid", n);
        check("t2 latency", 1 + n, 15);
        for (int c = 0; c < 4; c++) begin
            check("t2 data", m_out_data, lanes(3, 0));
            check("t2 last", m_out_last, c == 3);
            tick();
        end
        m_in_valid = 1'b0;
        check("t2 idle", m_busy, 1'b0);

        // 3: K=4 with in_valid 1,0,0,1,... ; A[i][k]=(i+1)(k+1), B[k][j]=j-k.
        m_k = 16'd4;
        m_start = 1'b1;
        tick();
        m_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 8; i++) m_A[i*8 +: 8] = 8'((i + 1) * (k + 1));
            for (int j = 0; j < 4; j++) m_B[j*8 +: 8] = 8'(j - k);
            m_in_valid = 1'b1;
            check("t3 in_ready beat", m_in_ready, 1'b1);
            tick();
            if (k < 3) begin
                m_in_valid = 1'b0;
                m_A = {8{8'h7f}};
                m_B = {4{8'h7f}};
                for (int g = 0; g < 2; g++) begin
                    check("t3 in_ready gap", m_in_ready, 1'b1);
                    tick();
                end
            end
        end
        m_in_valid = 1'b0;
        check("t3 in_ready flush", m_in_ready, 1'b0);
        wait_m_valid("t3 valid", n);
        for (int c = 0; c < 4; c++) begin
            col = 3 - c;
            check("t3 data", m_out_data, lanes(10 * col - 20, 10 * col - 20));
            check("t3 last", m_out_last, c == 3);
            tick();
        end

        // 5: K=1, A lane i=i+1, B lane j=j+1; stall beat 1, start during DRAIN.
        for (int i = 0; i < 8; i++) m_A[i*8 +: 8] = 8'(i + 1);
        for (int j = 0; j < 4; j++) m_B[j*8 +: 8] = 8'(j + 1);
        m_k = 16'd1;
        m_start = 1'b1;
        tick();
        m_start = 1'b0;
        m_in_valid = 1'b1;
        tick();
        m_in_valid = 1'b0;
        wait_m_valid("t5 valid", n);
        check("t5 beat0", m_out_data, lanes(4, 4));
        tick();
        m_out_ready = 1'b0;
        for (int h = 0; h < 5; h++) begin
            check("t5 hold data", m_out_data, lanes(3, 3));
            check("t5 hold last", m_out_last, 1'b0);
            check("t5 hold valid", m_out_valid, 1'b1);
            m_start = (h == 2);
            tick();
        end
        m_start = 1'b0;
        m_out_ready = 1'b1;
        check("t5 beat1", m_out_data, lanes(3, 3));
        tick();
        check("t5 beat2", m_out_data, lanes(2, 2));
        tick();
        check("t5 beat3", m_out_data, lanes(1, 1));
        check("t5 beat3 last", m_out_last, 1'b1);
        tick();
        check("t5 idle", m_busy, 1'b0);
        tick();
        check("t5 start ignored", {m_busy, m_out_valid}, 2'b00);

        // 5: K=0 drains N2 all-zero beats.
        m_k = 16'd0;
        m_start = 1'b1;
        tick();
        m_start = 1'b0;
        check("k0 in_ready", m_in_ready, 1'b0);
        check("k0 busy", m_busy, 1'b1);
        wait_m_valid("k0 valid", n);
        check("k0 latency", 1 + n, 12);
        for (int c = 0; c < 4; c++) begin
            check("k0 data", m_out_data, '0);
            check("k0 last", m_out_last, c == 3);
            tick();
        end
        check("k0 idle", m_busy, 1'b0);

        // 4: 16-bit accumulators, K=3, A=B=-128: wrap vs clamp.
        s_k = 16'd3;
        s_A = {8'h80, 8'h80};
        s_B = {8'h80, 8'h80};
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        s_in_valid = 1'b1;
        tick();
        tick();
        tick();
        s_in_valid = 1'b0;
        wait_s_valid("t4 valid");
        for (int c = 0; c < 2; c++) begin
            check("t4 wrap data", w_out_data, {16'hC000, 16'hC000});
            check("t4 sat data",  c_out_data, {16'h7FFF, 16'h7FFF});
            check("t4 last", {w_out_last, c_out_last}, (c == 1) ? 2'b11 : 2'b00);
            tick();
        end

        // 6: reset mid-LOAD.
        m_A = {8{8'sd1}};
        m_B = {4{8'sd1}};
        m_k = 16'd2;
        m_start = 1'b1;
        tick();
        m_start = 1'b0;
        m_in_valid = 1'b1;
        tick();
        check("t6 load in_ready", m_in_ready, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("t6 load rst in_ready", m_in_ready, 1'b0);
        check("t6 load rst busy", m_busy, 1'b0);
        m_in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // 6: reset mid-DRAIN.
        m_k = 16'd1;
        m_start = 1'b1;
        tick();
        m_start = 1'b0;
        m_in_valid = 1'b1;
        tick();
        m_in_valid = 1'b0;
        wait_m_valid("t6 drain valid", n);
        check("t6 drain data", m_out_data, lanes(1, 0));
        #2 rst = 1'b1;
        #1;
        check("t6 drain rst valid", m_out_valid, 1'b0);
        check("t6 drain rst data", m_out_data, '0);
        check("t6 drain rst last", m_out_last, 1'b0);
        check("t6 drain rst busy", m_busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // 6: next tile K=2, all 2 -> every lane 8.
        m_A = {8{8'sd2}};
        m_B = {4{8'sd2}};
        m_k = 16'd2;
        m_start = 1'b1;
        tick();
        m_start = 1'b0;
        m_in_valid = 1'b1;
        tick();
        tick();
        m_in_valid = 1'b0;
        wait_m_valid("t6 next valid", n);
        for (int c = 0; c < 4; c++) begin
            check("t6 next data", m_out_data, lanes(8, 0));
            check("t6 next last", m_out_last, c == 3);
            tick();
        end
        check("t6 next idle", m_busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
